ctrl_fetch_ifid: RTL

//  Fetch stage + IF/ID pipeline register for the 8-bit RISC-RNS core; consumer of ctrl_BranchPred.branch_taken.

---
 rtl/ctrl_fetch_ifid_pkg.sv | 30 +++
 rtl/ctrl_jmp_decode.sv | 28 ++
 rtl/ctrl_fetch_ifid.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ctrl_fetch_ifid_pkg.sv
// Shared constants for the fetch stage: opcodes, FSM encodings, conds bit indices.
// Also holds a saturating-increment helper for the optional perf counters.
package ctrl_fetch_ifid_pkg;

   localparam logic [4:0] OP_NOP = 5'h00;
   localparam logic [4:0] OP_JMP = 5'h10;
   localparam logic [4:0] OP_JEQ = 5'h11;
   localparam logic [4:0] OP_JLT = 5'h12;
   localparam logic [4:0] OP_JGT = 5'h13;
   localparam logic [4:0] OP_JC  = 5'h14;
   localparam logic [4:0] OP_HLT = 5'h1F;

   // Positions inside conds_IFID[0:4] = {jgt,jlt,jeq,jc,jmp}; shared with the branch predictor.
   localparam int CI_JGT = 0;
   localparam int CI_JLT = 1;
   localparam int CI_JEQ = 2;
   localparam int CI_JC  = 3;
   localparam int CI_JMP = 4;

   typedef enum logic [1:0] {
      FS_START = 2'd0,
      FS_RUN   = 2'd1,
      FS_HALT  = 2'd2
   } fetch_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/ctrl_jmp_decode.sv
// Combinational opcode decode of the IF/ID instruction into jump conditions and halt.
// All outputs are forced low when the IF/ID slot is not valid.
module ctrl_jmp_decode
   import ctrl_fetch_ifid_pkg::*;
(
   input  logic [4:0] opcode,
   input  logic       valid,
   output logic [0:4] conds,
   output logic       hlt
);

   always_comb begin
      conds = '0;
      hlt   = 1'b0;
      if (valid) begin
         case (opcode)
            OP_JGT:  conds[CI_JGT] = 1'b1;
            OP_JLT:  conds[CI_JLT] = 1'b1;
            OP_JEQ:  conds[CI_JEQ] = 1'b1;
            OP_JC:   conds[CI_JC]  = 1'b1;
            OP_JMP:  conds[CI_JMP] = 1'b1;
            OP_HLT:  hlt           = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ctrl_fetch_ifid.sv
// Fetch stage and IF/ID register: PC, squash on taken branch, valid tracking, halt.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
//
// state    | meaning
// FS_START | first cycle after reset; performs the first fetch
// FS_RUN   | normal fetch, redirect on taken branch, watch for HLT
// FS_HALT  | HLT reached; PC frozen, IF/ID invalid until reset
module ctrl_fetch_ifid
   import ctrl_fetch_ifid_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               branch_taken,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic               ifid_valid,
   output logic [0:4]         conds_IFID,
   output logic               invalidate_instr,
   output logic               halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0]        perf_fetch_cnt,
   output logic [15:0]        perf_squash_cnt
`endif
);

   localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, {(INSTR_W-5){1'b0}}};

   fetch_state_t       state, state_nxt;
   logic [PC_W-1:0]    pc, pc_nxt;
   logic [INSTR_W-1:0] instr_nxt;
   logic [PC_W-1:0]    ifid_pc_nxt;
   logic               valid_nxt;
   logic               idex_valid;
   logic               dec_hlt;
   logic               do_fetch;
   logic               do_squash;

   ctrl_jmp_decode u_jmp_decode (
      .opcode (ifid_instr[INSTR_W-1 -: 5]),
      .valid  (ifid_valid),
      .conds  (conds_IFID),
      .hlt    (dec_hlt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= FS_START;
         pc         <= RESET_PC;
         ifid_instr <= NOP_INSTR;
         ifid_pc    <= '0;
         ifid_valid <= 1'b0;
         idex_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         ifid_instr <= instr_nxt;
         ifid_pc    <= ifid_pc_nxt;
         ifid_valid <= valid_nxt;
         idex_valid <= stall ? 1'b0 : ifid_valid;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      instr_nxt   = ifid_instr;
      ifid_pc_nxt = ifid_pc;
      valid_nxt   = ifid_valid;
      do_fetch    = 1'b0;
      do_squash   = 1'b0;
      if (!stall) begin
         case (state)
            FS_START: begin
               do_fetch  = 1'b1;
               state_nxt = FS_RUN;
            end
            FS_RUN: begin
               if (dec_hlt) begin
                  state_nxt = FS_HALT;
                  instr_nxt = NOP_INSTR;
                  valid_nxt = 1'b0;
               end else if (branch_taken && ifid_valid) begin
                  // Wrong-path fetch at pc is dropped; target is fetched next cycle.
                  do_squash = 1'b1;
                  pc_nxt    = ifid_instr[PC_W-1:0];
                  instr_nxt = NOP_INSTR;
                  valid_nxt = 1'b0;
               end else begin
                  do_fetch = 1'b1;
               end
            end
            FS_HALT: begin
               instr_nxt = NOP_INSTR;
               valid_nxt = 1'b0;
            end
            default: state_nxt = FS_START;
         endcase
      end
      if (do_fetch) begin
         pc_nxt      = pc + PC_W'(1);
         instr_nxt   = imem_rdata;
         ifid_pc_nxt = pc;
         valid_nxt   = 1'b1;
      end
   end

   assign imem_addr        = pc;
   assign invalidate_instr = !idex_valid;
   assign halted           = (state == FS_HALT);

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetch_cnt  <= '0;
         perf_squash_cnt <= '0;
      end else begin
         if (do_fetch)  perf_fetch_cnt  <= sat_inc16(perf_fetch_cnt);
         if (do_squash) perf_squash_cnt <= sat_inc16(perf_squash_cnt);
      end
   end
`endif

endmodule
